round_robin_mux_arbiter: RTL

ROUND_ROBIN_MUX_ARBITER -- requirements
Module: round_robin_mux_arbiter

---
 rtl/round_robin_mux_arbiter_pkg.sv | 15 +
 rtl/mux_m_to_1.sv | 13 +
 rtl/round_robin_mux_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/round_robin_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding and
// default parameter values.
package round_robin_mux_arbiter_pkg;

  // IDLE: nobody owns the mux; BUSY: exactly one requester owns it.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int default_number_of_input  = 4;
  localparam int default_number_of_select = 2;
  localparam int default_max_hold         = 4;

endpackage

// File: rtl/mux_m_to_1.sv
// Plain M-to-1 single-bit multiplexer: y = in[select].
module mux_m_to_1 #(
  parameter int number_of_input  = 4,
  parameter int number_of_select = 2
) (
  input  logic [number_of_select-1:0] select,
  input  logic [number_of_input-1:0]  in,
  output logic                        y
);

  assign y = in[select];

endmodule

// File: rtl/round_robin_mux_arbiter.sv
// Round-robin arbiter that hands a single-bit mux to one requester at a time,
// limiting each owner to max_hold consecutive cycles while others wait.
module round_robin_mux_arbiter
  import round_robin_mux_arbiter_pkg::*;
#(
  parameter int number_of_input  = default_number_of_input,
  parameter int number_of_select = default_number_of_select,
  parameter int max_hold         = default_max_hold
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [number_of_input-1:0]  req,
  input  logic [number_of_input-1:0]  in,
  output logic [number_of_input-1:0]  grant,
  output logic [number_of_select-1:0] select,
  output logic                        valid,
  output logic                        y
);

  localparam int hold_width = $clog2(max_hold + 1);
  localparam logic [hold_width-1:0]       hold_limit = hold_width'(max_hold);
  localparam logic [hold_width-1:0]       hold_one   = hold_width'(1);
  localparam logic [number_of_select-1:0] sel_one    = number_of_select'(1);
  localparam logic [number_of_input-1:0]  grant_one  = number_of_input'(1);

  state_t                        state, state_next;
  logic [number_of_input-1:0]    grant_next;
  logic [number_of_select-1:0]   select_next;
  logic                          valid_next;
  logic [hold_width-1:0]         hold_cnt, hold_next;
  logic [number_of_select-1:0]   ptr, ptr_next;
  logic [number_of_select-1:0]   winner;
  logic                          any_req, owner_req, other_req;
  logic                          take_winner, go_idle;
  logic                          mux_y;

  // Winner: first asserted request scanning ptr, ptr+1, ... (wraps because
  // the index is exactly number_of_select bits wide and N is a power of two).
  // Scanning downward lets the lowest offset overwrite, so no break is needed.
  always_comb begin
    winner = '0;
    for (int i = number_of_input - 1; i >= 0; i--) begin
      if (req[ptr + number_of_select'(i)]) winner = ptr + number_of_select'(i);
    end
  end

  assign any_req   = |req;
  assign owner_req = req[select];
  // grant is zero in IDLE, so this is "anyone but the current owner" in BUSY.
  assign other_req = |(req & ~grant);

  // Next-state and next-output decode. In BUSY ptr always equals owner+1,
  // so the scan naturally puts the current owner last.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    grant_next  = grant;
    select_next = select;
    valid_next  = valid;
    hold_next   = hold_cnt;
    ptr_next    = ptr;
    take_winner = 1'b0;
    go_idle     = 1'b0;

    case (state)
      IDLE: take_winner = any_req;
      BUSY: begin
        if (!owner_req) begin
          // Owner released: hand over directly, or fall idle.
          if (other_req) take_winner = 1'b1;
          else           go_idle     = 1'b1;
        end else if (hold_cnt < hold_limit) begin
          hold_next = hold_cnt + hold_one;
        end else if (other_req) begin
          take_winner = 1'b1;
        end else begin
          hold_next = hold_one;
        end
      end
    endcase

    if (take_winner) begin
      state_next  = BUSY;
      grant_next  = grant_one << winner;
      select_next = winner;
      valid_next  = 1'b1;
      hold_next   = hold_one;
      ptr_next    = winner + sel_one;
    end

    if (go_idle) begin
      state_next  = IDLE;
      grant_next  = '0;
      select_next = '0;
      valid_next  = 1'b0;
      hold_next   = '0;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      select   <= '0;
      valid    <= 1'b0;
      hold_cnt <= '0;
      ptr      <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      select   <= select_next;
      valid    <= valid_next;
      hold_cnt <= hold_next;
      ptr      <= ptr_next;
    end
  end

  mux_m_to_1 #(
    .number_of_input (number_of_input),
    .number_of_select(number_of_select)
  ) u_mux (
    .select(select),
    .in    (in),
    .y     (mux_y)
  );

  assign y = valid & mux_y;

endmodule
